reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/mini16_pkg.sv | 33 +++
 rtl/cdc_synchronizer.sv | 44 ++++
 rtl/reset_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini16_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mini16_pkg
// Description : Shared definitions for the reset sequencer: FSM state
//               encodings (also driven onto the LED state port), ready-bit
//               values, loss-counter width and a small elaboration helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mini16_pkg;

    localparam int STATE_W = 2;

    // Encodings are visible on the state output, so they are fixed here.
    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

    localparam logic READY_ON  = 1'b1;
    localparam logic READY_OFF = 1'b0;

    localparam int              LOSS_W   = 8;
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_synchronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cdc_synchronizer
// Description : Multi-flop synchroniser for asynchronous level inputs.
//               The reset value is a port so each instance can choose the
//               "safe" level of its signal (e.g. unlocked, button released).
// Ports       : clk      - destination clock
//               reset_n  - asynchronous active-low reset
//               rst_val  - value loaded into every stage while in reset
//               d        - asynchronous input
//               q        - synchronised output (STAGES cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= rst_val;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / user reset sequencer. Waits for PLL lock with no
//               button press, holds all domain resets for HOLD_CYCLES, then
//               releases them one by one (index order) every STAGE_GAP
//               cycles and flags ready. Any abort condition slams all resets
//               back on. Lock losses seen while running are counted
//               (saturating).
// Config      : RESET_SEQ_DEBOUNCE_EN - when defined, a button press is only
//               honoured after DEBOUNCE_CYCLES continuous low samples.
// Ports       : clk        - single clock
//               reset_n    - asynchronous active-low reset
//               pll_locked - asynchronous PLL lock indicator
//               button_n   - asynchronous active-low user reset request
//               reset_out  - active-high per-domain resets (registered)
//               ready      - all channels released (registered)
//               state      - FSM state for LED display (registered)
//               loss_count - saturating lock-loss-in-RUN count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import mini16_pkg::*;
#(
    parameter int CHANNELS        = 3,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic                button_n,
    output logic [CHANNELS-1:0] reset_out,
    output logic                ready,
    output logic [STATE_W-1:0]  state,
    output logic [LOSS_W-1:0]   loss_count
);

    // One cycle counter serves both HOLD and RELEASE, so it is sized for the
    // longer of the two intervals.
    localparam int CYC_W  = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int CHAN_W = $clog2(CHANNELS + 1);

    localparam logic [CYC_W-1:0]  HOLD_LAST = CYC_W'(HOLD_CYCLES - 1);
    localparam logic [CYC_W-1:0]  GAP_LAST  = CYC_W'(STAGE_GAP - 1);
    localparam logic [CHAN_W-1:0] CHAN_ALL  = CHAN_W'(CHANNELS);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic locked_sync;
    logic button_sync;
    logic press;

    cdc_synchronizer #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_val (1'b0),
        .d       (pll_locked),
        .q       (locked_sync)
    );

    cdc_synchronizer #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_button (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_val (1'b1),
        .d       (button_n),
        .q       (button_sync)
    );

    // ------------------------------------------------------------------
    // Button press qualification
    // ------------------------------------------------------------------
`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_CYCLES);

    logic [DB_W-1:0] db_cnt;

    // Counts consecutive low samples and parks at DB_DONE; any high sample
    // clears it, which also makes release take effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
        end else if (button_sync) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_DONE) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press = (db_cnt == DB_DONE);
`else
    assign press = ~button_sync;

    // Debounce length is meaningless without the debouncer; it is referenced
    // here only so the parameter list stays identical across builds.
    if (DEBOUNCE_CYCLES < 0) begin : g_debounce_unused
    end
`endif

    logic start_ok;
    logic abort;

    assign start_ok = locked_sync & ~press;
    assign abort    = ~start_ok;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    seq_state_t          state_q,  state_nxt;
    logic [CHANNELS-1:0] rst_q,    rst_nxt;
    logic                ready_q,  ready_nxt;
    logic [CYC_W-1:0]    cyc_q,    cyc_nxt;
    logic [CHAN_W-1:0]   chan_q,   chan_nxt;
    logic [LOSS_W-1:0]   loss_q,   loss_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ASSERT;
            rst_q   <= '1;
            ready_q <= READY_OFF;
            cyc_q   <= '0;
            chan_q  <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_nxt;
            rst_q   <= rst_nxt;
            ready_q <= ready_nxt;
            cyc_q   <= cyc_nxt;
            chan_q  <= chan_nxt;
            loss_q  <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        rst_nxt   = rst_q;
        ready_nxt = ready_q;
        cyc_nxt   = cyc_q;
        chan_nxt  = chan_q;
        loss_nxt  = loss_q;

        if ((state_q != ST_ASSERT) && abort) begin
            state_nxt = ST_ASSERT;
            rst_nxt   = '1;
            ready_nxt = READY_OFF;
            cyc_nxt   = '0;
            chan_nxt  = '0;
            // Only lock loss while running is counted; a simultaneous button
            // press still yields a single increment.
            if ((state_q == ST_RUN) && !locked_sync && (loss_q != LOSS_MAX)) begin
                loss_nxt = loss_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rst_nxt   = '1;
                    ready_nxt = READY_OFF;
                    cyc_nxt   = '0;
                    chan_nxt  = '0;
                    if (start_ok) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cyc_q == HOLD_LAST) begin
                        state_nxt = ST_RELEASE;
                        // Shifting a zero in from the bottom releases the
                        // channels strictly in index order.
                        rst_nxt   = rst_q << 1;
                        chan_nxt  = CHAN_W'(1);
                        cyc_nxt   = '0;
                    end else begin
                        cyc_nxt = cyc_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (chan_q == CHAN_ALL) begin
                        state_nxt = ST_RUN;
                        ready_nxt = READY_ON;
                    end else if (cyc_q == GAP_LAST) begin
                        rst_nxt  = rst_q << 1;
                        chan_nxt = chan_q + 1'b1;
                        cyc_nxt  = '0;
                    end else begin
                        cyc_nxt = cyc_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_nxt = ST_ASSERT;
                end
            endcase
        end
    end

    assign reset_out  = rst_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer with
//               CHANNELS=3, HOLD_CYCLES=8, STAGE_GAP=4, SYNC_STAGES=2,
//               DEBOUNCE_CYCLES=5. Builds with or without
//               RESET_SEQ_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       button_n;
    logic [2:0] reset_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS        (3),
        .HOLD_CYCLES     (8),
        .STAGE_GAP       (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .button_n   (button_n),
        .reset_out  (reset_out),
        .ready      (ready),
        .state      (state),
        .loss_count (loss_count)
    );

    // Advance n rising edges, then step 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        button_n   = 1'b1;
        tick(2);
        checks++;
        if ({state, ready, reset_out} !== 6'b00_0_111) begin
            errors++;
            $display("FAIL reset_outputs state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b00_0_111);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_loss loss_count=%0d expected=0", loss_count);
        end
    endtask

    // Called 1 ns after an edge at which lock (and reset_n) became high with
    // the synchronisers holding 0. T0 is the third following edge.
    task automatic test_release_timing(input string tag);
        int         dt [9] = '{2, 1, 7, 1, 3, 1, 3, 1, 1};
        logic [5:0] ex [9] = '{6'b00_0_111,   // T0-1  ASSERT
                               6'b01_0_111,   // T0    HOLD
                               6'b01_0_111,   // T0+7
                               6'b10_0_110,   // T0+8  ch0 released
                               6'b10_0_110,   // T0+11
                               6'b10_0_100,   // T0+12 ch1 released
                               6'b10_0_100,   // T0+15
                               6'b10_0_000,   // T0+16 ch2 released
                               6'b11_1_000};  // T0+17 RUN, ready
        for (int i = 0; i < 9; i++) begin
            tick(dt[i]);
            checks++;
            if ({state, ready, reset_out} !== ex[i]) begin
                errors++;
                $display("FAIL %s step %0d state/ready/reset_out=%b expected=%b",
                         tag, i, {state, ready, reset_out}, ex[i]);
            end
        end
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (state !== 2'd3 && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (state !== 2'd3 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_run state=%0d ready=%b expected state=3 ready=1",
                     tag, state, ready);
        end
    endtask

    task automatic test_power_up;
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        test_release_timing("power_up");
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL power_up_loss loss_count=%0d expected=0", loss_count);
        end
    endtask

    task automatic test_button_abort;
        button_n = 1'b0;
`ifdef RESET_SEQ_DEBOUNCE_EN
        // 4-cycle pulse is shorter than the debounce time: must be ignored.
        tick(4);
        button_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (state !== 2'd3 || reset_out !== 3'b000) begin
                errors++;
                $display("FAIL short_pulse cycle %0d state=%0d reset_out=%b expected state=3 reset_out=000",
                         i, state, reset_out);
            end
        end
        // 6-cycle pulse: debounce completes after E7, abort lands on E8.
        button_n = 1'b0;
        tick(6);
        button_n = 1'b1;
        tick(1);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL long_pulse_pre state=%0d expected=3", state);
        end
        tick(1);
`else
        // Press acts as soon as it is synchronised: abort on the third edge.
        tick(2);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL press_pre state=%0d expected=3", state);
        end
        tick(1);
`endif
        checks++;
        if ({state, ready, reset_out} !== 6'b00_0_111) begin
            errors++;
            $display("FAIL button_abort state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b00_0_111);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL button_no_loss loss_count=%0d expected=0", loss_count);
        end
`ifndef RESET_SEQ_DEBOUNCE_EN
        tick(3);
        button_n = 1'b1;
`endif
        wait_run("button");
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL button_loss_after loss_count=%0d expected=0", loss_count);
        end
    endtask

    task automatic test_mid_release_abort;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL mid_t0 state=%0d expected=1", state);
        end
        tick(8);
        checks++;
        if ({state, ready, reset_out} !== 6'b10_0_110) begin
            errors++;
            $display("FAIL mid_t8 state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b10_0_110);
        end
        tick(2);
        pll_locked = 1'b0;          // dropped just after edge T0+10
        tick(2);
        checks++;
        if ({state, ready, reset_out} !== 6'b10_0_100) begin
            errors++;
            $display("FAIL mid_t12 state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b10_0_100);
        end
        tick(1);
        checks++;
        if ({state, ready, reset_out} !== 6'b00_0_111) begin
            errors++;
            $display("FAIL mid_abort state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b00_0_111);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_abort_loss loss_count=%0d expected=0", loss_count);
        end
        tick(2);
        pll_locked = 1'b1;
        test_release_timing("relock");
    endtask

    task automatic test_loss_saturation;
        // Lock loss and button press together count once.
        pll_locked = 1'b0;
        button_n   = 1'b0;
        tick(3);
        checks++;
        if (state !== 2'd0 || loss_count !== 8'd1) begin
            errors++;
            $display("FAIL simultaneous_abort state=%0d loss_count=%0d expected state=0 loss_count=1",
                     state, loss_count);
        end
        tick(4);
        pll_locked = 1'b1;
        button_n   = 1'b1;
        wait_run("simultaneous");
        checks++;
        if (loss_count !== 8'd1) begin
            errors++;
            $display("FAIL simultaneous_loss loss_count=%0d expected=1", loss_count);
        end

        for (int i = 0; i < 300; i++) begin
            int n;
            pll_locked = 1'b0;
            n = 0;
            while (state !== 2'd0 && n < 10) begin
                tick(1);
                n++;
            end
            checks++;
            if (state !== 2'd0) begin
                errors++;
                $display("FAIL loss_toggle %0d no abort state=%0d expected=0", i, state);
                break;
            end
            pll_locked = 1'b1;
            n = 0;
            while (state !== 2'd3 && n < 40) begin
                tick(1);
                n++;
            end
            checks++;
            if (state !== 2'd3) begin
                errors++;
                $display("FAIL loss_toggle %0d no run state=%0d expected=3", i, state);
                break;
            end
            if (i == 0) begin
                checks++;
                if (loss_count !== 8'd2) begin
                    errors++;
                    $display("FAIL loss_first loss_count=%0d expected=2", loss_count);
                end
            end
        end
        checks++;
        if (loss_count !== 8'd255) begin
            errors++;
            $display("FAIL loss_saturate loss_count=%0d expected=255", loss_count);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;                          // well before the next rising edge
        checks++;
        if ({state, ready, reset_out} !== 6'b00_0_111) begin
            errors++;
            $display("FAIL async_reset state/ready/reset_out=%b expected=%b",
                     {state, ready, reset_out}, 6'b00_0_111);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_loss loss_count=%0d expected=0", loss_count);
        end
        #2;
        reset_n = 1'b1;
        test_release_timing("after_async_reset");
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_button_abort;
        test_mid_release_abort;
        test_loss_saturation;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
